// File: rtl/pc_redirect_ctrl_if.sv
// Redirect bundle between execute/exception sources, fetch and the redirect sequencer.
// master = requesters/fetch side, slave = pc_redirect_ctrl.
interface pc_redirect_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              trap_enable;
    logic [ADDR_W-1:0] trap_handler_addr;
    logic              xret_enable;
    logic [ADDR_W-1:0] epc_value;
    logic              ex_redirect_en;
    logic [ADDR_W-1:0] ex_redirect_addr;
    logic              imem_req_fire;
    logic              imem_resp_fire;
    logic              fetch_ready;
    logic              flush;
    logic              fetch_stall;
    logic              discard_resp;
    logic              pc_load_en;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              redirect_busy;
    logic [1:0]        redirect_src;

    modport master (
        output trap_enable, trap_handler_addr, xret_enable, epc_value,
               ex_redirect_en, ex_redirect_addr, imem_req_fire, imem_resp_fire, fetch_ready,
        input  flush, fetch_stall, discard_resp, pc_load_en, pc_load_addr,
               redirect_busy, redirect_src
    );

    modport slave (
        input  trap_enable, trap_handler_addr, xret_enable, epc_value,
               ex_redirect_en, ex_redirect_addr, imem_req_fire, imem_resp_fire, fetch_ready,
        output flush, fetch_stall, discard_resp, pc_load_en, pc_load_addr,
               redirect_busy, redirect_src
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: trap > xret > ex arbitration, flush, drain in-flight imem, then load fetch PC.
// Latency: request to pc_load_en is 3 cycles minimum (longer while imem responses are outstanding).
// Backpressure: pc_load_en/pc_load_addr held until fetch_ready; REDIRECT_PERF_EN adds perf counters.
module pc_redirect_ctrl #(
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                nrst,
    pc_redirect_ctrl_if.slave   rif
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0]         perf_redirect_cnt,
    output logic [31:0]         perf_stall_cycles
`endif
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        src_q, src_d;
    logic [1:0]        req_src;
    logic [ADDR_W-1:0] req_addr;

    // Source encoding doubles as priority: a larger code preempts a smaller one.
    always_comb begin
        req_src  = 2'd0;
        req_addr = '0;
        if (rif.trap_enable) begin
            req_src  = 2'd3;
            req_addr = rif.trap_handler_addr;
        end else if (rif.xret_enable) begin
            req_src  = 2'd2;
            req_addr = rif.epc_value;
        end else if (rif.ex_redirect_en) begin
            req_src  = 2'd1;
            req_addr = rif.ex_redirect_addr;
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (rif.imem_req_fire && !rif.imem_resp_fire && outst_q != MAX_CNT)
            outst_d = outst_q + 1'b1;
        else if (rif.imem_resp_fire && !rif.imem_req_fire && outst_q != '0)
            outst_d = outst_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        src_d   = src_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            FLUSH: state_d = DRAIN;
            DRAIN: if (outst_d == '0) state_d = ISSUE;
            ISSUE: begin
                if (rif.fetch_ready) begin
                    state_d = IDLE;
                    src_d   = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        // src_q is 0 in IDLE, so any request starts a redirect; while busy only a
        // strictly higher-priority source restarts, including in the handshake cycle.
        if (req_src > src_q) begin
            addr_d  = req_addr;
            src_d   = req_src;
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            outst_q <= '0;
            addr_q  <= '0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
        end
    end

    assign rif.flush         = (state_q == FLUSH);
    assign rif.fetch_stall   = (state_q != IDLE);
    assign rif.discard_resp  = (state_q == FLUSH) || (state_q == DRAIN);
    assign rif.pc_load_en    = (state_q == ISSUE);
    assign rif.pc_load_addr  = (state_q == ISSUE) ? addr_q : '0;
    assign rif.redirect_busy = (state_q != IDLE);
    assign rif.redirect_src  = src_q;

`ifdef REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_redirect_cnt <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state_q == ISSUE && rif.fetch_ready)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            if (state_q != IDLE)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule
